// File: rtl/counter_pkg.sv
// Shared mode and direction encodings for the event/interval counter.
package counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2
  } mode_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: ticks once every i_div+1 enabled cycles.
module counter_prescaler #(
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_enable,
  input  logic                  i_sync_clr,
  input  logic [PRESCALE_W-1:0] i_div,
  output logic                  o_tick
);

  logic [PRESCALE_W-1:0] pre_q, pre_d;

  // >= so that lowering i_div below the running count ticks on the next enabled cycle.
  assign o_tick = i_enable && !i_sync_clr && (pre_q >= i_div);

  always_comb begin
    pre_d = pre_q;
    if (i_sync_clr) begin
      pre_d = '0;
    end else if (o_tick) begin
      pre_d = '0;
    end else if (i_enable) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/counter_mode_ctl.sv
// Up/down counter with runtime limit, prescaler and wrap/saturate/one-shot modes.
module counter_mode_ctl
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4,
  parameter int unsigned RESET_VAL  = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_enable,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_load_val,
  input  logic                  i_dir,
  input  logic [1:0]            i_mode,
  input  logic [WIDTH-1:0]      i_limit,
  input  logic [PRESCALE_W-1:0] i_prescale,
  output logic [WIDTH-1:0]      o_count,
  output logic                  o_tc,
  output logic                  o_wrap,
  output logic                  o_done
);

  localparam logic [WIDTH-1:0] ResetVal = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             tick;
  logic             is_sat, is_oneshot, is_wrap;
  logic [WIDTH-1:0] term;

  counter_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk       (clk),
    .resetn    (resetn),
    .i_enable  (i_enable),
    .i_sync_clr(i_clear | i_load),
    .i_div     (i_prescale),
    .o_tick    (tick)
  );

  // Reserved mode 3 falls through to wrap behaviour.
  assign is_sat     = (i_mode == MODE_SAT);
  assign is_oneshot = (i_mode == MODE_ONESHOT);
  assign is_wrap    = !is_sat && !is_oneshot;
  assign term       = (i_dir == DIR_UP) ? i_limit : '0;

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    wrap_d  = 1'b0;
    done_d  = done_q;
    if (i_clear) begin
      count_d = ResetVal;
      done_d  = 1'b0;
    end else if (i_load) begin
      count_d = (i_load_val > i_limit) ? i_limit : i_load_val;
      done_d  = 1'b0;
    end else if (tick && !(is_oneshot && done_q)) begin
      if (i_dir == DIR_UP) begin
        if (count_q >= i_limit) begin
          if (is_wrap) begin
            count_d = '0;
            wrap_d  = 1'b1;
          end else if (count_q > i_limit) begin
            count_d = i_limit;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          if (is_wrap) begin
            count_d = i_limit;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      // Terminal pulse only when the step actually moved onto the terminal value.
      tc_d = (count_d != count_q) && (count_d == term);
      if (is_oneshot && tc_d) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= ResetVal;
      tc_q    <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign o_count = count_q;
  assign o_tc    = tc_q;
  assign o_wrap  = wrap_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_counter_mode_ctl.sv
// Directed bench for counter_mode_ctl; expected {count,tc,wrap,done} are hand-computed.
module tb_counter_mode_ctl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       i_enable = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_load = 1'b0;
  logic [7:0] i_load_val = 8'd0;
  logic       i_dir = 1'b1;
  logic [1:0] i_mode = 2'd0;
  logic [7:0] i_limit = 8'd5;
  logic [3:0] i_prescale = 4'd0;
  logic [7:0] o_count;
  logic       o_tc;
  logic       o_wrap;
  logic       o_done;
  logic [10:0] obs;

  int vectors = 0;
  int errors  = 0;

  counter_mode_ctl #(
    .WIDTH     (8),
    .PRESCALE_W(4),
    .RESET_VAL (0)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_enable  (i_enable),
    .i_clear   (i_clear),
    .i_load    (i_load),
    .i_load_val(i_load_val),
    .i_dir     (i_dir),
    .i_mode    (i_mode),
    .i_limit   (i_limit),
    .i_prescale(i_prescale),
    .o_count   (o_count),
    .o_tc      (o_tc),
    .o_wrap    (o_wrap),
    .o_done    (o_done)
  );

  always #5 clk = ~clk;

  assign obs = {o_count, o_tc, o_wrap, o_done};

  function automatic logic [10:0] pk(input logic [7:0] c, input logic t, input logic w,
                                     input logic d);
    return {c, t, w, d};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [10:0] exp;
    resetn = 1'b0;
    #3;
    exp = pk(8'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", obs, exp);
    end
    cyc();
    resetn = 1'b1;
  endtask

  task automatic test_wrap_up;
    logic [7:0]  ec[8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};
    logic [10:0] exp;
    i_limit = 8'd5; i_mode = 2'd0; i_dir = 1'b1; i_prescale = 4'd0; i_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      exp = pk(ec[i], i == 4, i == 5, 1'b0);
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL wrap_up[%0d] got=%h exp=%h", i, obs, exp);
      end
    end
    i_enable = 1'b0;
  endtask

  task automatic test_sat_down;
    logic [7:0]  ec[6] = '{8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    logic [10:0] exp;
    i_mode = 2'd1; i_dir = 1'b0; i_load = 1'b1; i_load_val = 8'd3;
    cyc();
    i_load = 1'b0;
    exp = pk(8'd3, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL sat_load got=%h exp=%h", obs, exp);
    end
    i_enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      exp = pk(ec[i], i == 2, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL sat_down[%0d] got=%h exp=%h", i, obs, exp);
      end
    end
    i_enable = 1'b0;
  endtask

  task automatic test_oneshot;
    logic [7:0]  ec[5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
    logic [10:0] exp;
    i_mode = 2'd2; i_dir = 1'b1; i_limit = 8'd3; i_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      exp = pk(ec[i], i == 2, 1'b0, i >= 2);
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL oneshot[%0d] got=%h exp=%h", i, obs, exp);
      end
    end
    // Leaving one-shot resumes counting; done stays sticky.
    i_mode = 2'd0;
    cyc();
    exp = pk(8'd0, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL oneshot_resume got=%h exp=%h", obs, exp);
    end
    i_mode = 2'd2;
    cyc();
    exp = pk(8'd0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL oneshot_inhibit got=%h exp=%h", obs, exp);
    end
    i_load = 1'b1; i_load_val = 8'd9;
    cyc();
    i_load = 1'b0; i_enable = 1'b0;
    exp = pk(8'd3, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL oneshot_load_clamp got=%h exp=%h", obs, exp);
    end
  endtask

  task automatic test_prescale;
    logic [7:0]  ec[9] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3};
    logic [7:0]  gc[5] = '{8'd3, 8'd3, 8'd3, 8'd3, 8'd4};
    logic        ge[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [10:0] exp;
    i_mode = 2'd0; i_dir = 1'b1; i_limit = 8'd10; i_prescale = 4'd2; i_clear = 1'b1;
    cyc();
    i_clear = 1'b0;
    exp = pk(8'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clear got=%h exp=%h", obs, exp);
    end
    i_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      exp = pk(ec[i], 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL prescale[%0d] got=%h exp=%h", i, obs, exp);
      end
    end
    for (int i = 0; i < 5; i++) begin
      i_enable = ge[i];
      cyc();
      exp = pk(gc[i], 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL prescale_gap[%0d] got=%h exp=%h", i, obs, exp);
      end
    end
    i_enable = 1'b0;
  endtask

  task automatic test_limit_change;
    logic [10:0] exp;
    i_prescale = 4'd0; i_dir = 1'b1;
    // Saturate: count above lowered limit steps up to the limit.
    i_mode = 2'd1; i_limit = 8'd10; i_load_val = 8'd7; i_load = 1'b1;
    cyc();
    i_load = 1'b0; i_limit = 8'd4; i_enable = 1'b1;
    cyc();
    i_enable = 1'b0;
    exp = pk(8'd4, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL sat_over_limit got=%h exp=%h", obs, exp);
    end
    i_mode = 2'd0; i_limit = 8'd10; i_load = 1'b1;
    cyc();
    i_load = 1'b0; i_limit = 8'd4; i_enable = 1'b1;
    cyc();
    i_enable = 1'b0;
    exp = pk(8'd0, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL wrap_over_limit got=%h exp=%h", obs, exp);
    end
    i_limit = 8'd10; i_load_val = 8'd5; i_load = 1'b1;
    cyc();
    i_load = 1'b0;
    exp = pk(8'd5, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL load_5 got=%h exp=%h", obs, exp);
    end
    i_clear = 1'b1; i_load = 1'b1; i_load_val = 8'd6;
    cyc();
    i_clear = 1'b0; i_load = 1'b0;
    exp = pk(8'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL clear_over_load got=%h exp=%h", obs, exp);
    end
    // Zero limit: every step is terminal.
    i_load_val = 8'd3; i_load = 1'b1;
    cyc();
    i_load = 1'b0; i_limit = 8'd0; i_enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      exp = pk(8'd0, i == 0, 1'b1, 1'b0);
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL zero_limit[%0d] got=%h exp=%h", i, obs, exp);
      end
    end
    i_enable = 1'b0;
  endtask

  task automatic test_async_reset;
    logic [7:0]  ec[3] = '{8'd0, 8'd0, 8'd1};
    logic [10:0] exp;
    i_mode = 2'd0; i_dir = 1'b1; i_limit = 8'd10; i_prescale = 4'd2;
    i_load_val = 8'd4; i_load = 1'b1;
    cyc();
    i_load = 1'b0; i_enable = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    exp = pk(8'd5, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL pre_reset_count got=%h exp=%h", obs, exp);
    end
    resetn = 1'b0;
    #2;
    exp = pk(8'd0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL async_reset got=%h exp=%h", obs, exp);
    end
    cyc();
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp = pk(ec[i], 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL post_reset[%0d] got=%h exp=%h", i, obs, exp);
      end
    end
    i_enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_sat_down();
    test_oneshot();
    test_prescale();
    test_limit_change();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/counter_mode_ctl.md
Name: counter_mode_ctl

Overview:
Parametrised up/down counter with a runtime limit, a programmable prescaler and three wrap modes (wrap, saturate, one-shot). It adds synchronous clear, parallel load, terminal-count and wrap pulses, and a one-shot done flag. It serves as the general-purpose event/interval counter for timers, PWM periods and timeouts.

Parameters:
WIDTH, 8, bit width of the count, the limit and the load value (min 2).
PRESCALE_W, 4, width of the prescaler divide input.
RESET_VAL, 0, value of o_count after reset and after clear (must be <= 2**WIDTH-1).

Ports:
clk  in  1  clock, rising edge.
resetn  in  1  asynchronous active-low reset.
i_enable  in  1  count enable; a step occurs only when the prescaler tick is also high.
i_clear  in  1  synchronous clear to RESET_VAL; also clears the prescaler and o_done.
i_load  in  1  synchronous load of i_load_val; also clears the prescaler and o_done.
i_load_val  in  WIDTH  load value; clamped to i_limit.
i_dir  in  1  1 = up, 0 = down.
i_mode  in  2  0 = WRAP, 1 = SAT, 2 = ONESHOT, 3 = reserved (behaves as WRAP).
i_limit  in  WIDTH  upper bound of the count range [0, i_limit].
i_prescale  in  PRESCALE_W  step every i_prescale+1 enabled cycles; 0 = every enabled cycle.
o_count  out  WIDTH  current count.
o_tc  out  1  one-cycle pulse when a step lands on the terminal value.
o_wrap  out  1  one-cycle pulse when a step wraps (WRAP mode only).
o_done  out  1  sticky flag set when ONESHOT mode reaches terminal.

Behaviour:
- Reset is asynchronous and active-low on resetn; clock is clk. The following values apply while resetn is low:
  - o_count = RESET_VAL
  - o_tc = 0, o_wrap = 0, o_done = 0
  - prescaler count = 0
- All outputs are registered.
- Control priority per cycle: clear > load > step > hold.
- Load: o_count <= min(i_load_val, i_limit). o_tc and o_wrap stay 0 on load and clear cycles.
- Prescaler:
  - Internal counter runs 0..i_prescale and advances only when i_enable=1.
  - tick = (i_enable && pre_cnt == i_prescale); pre_cnt returns to 0 on tick.
  - A change of i_prescale mid-count takes effect immediately; if pre_cnt > i_prescale, the next enabled cycle ticks.
- Terminal value: i_limit when counting up, 0 when counting down.
- Step on tick, by mode:
  - Not at terminal: o_count +/- 1 per i_dir.
  - At terminal, WRAP: up wraps to 0, down wraps to i_limit; o_wrap=1 that cycle.
  - At terminal, SAT: holds; no o_tc, no o_wrap.
  - At terminal, ONESHOT: holds; counting is inhibited while o_done=1.
- o_tc: registered pulse, high for exactly the cycle after the step whose result equals the terminal value (high together with the new o_count).
- ONESHOT: o_done sets in the same cycle o_tc asserts and stays set until clear or load. Changing i_mode away from ONESHOT while o_done=1 resumes counting; o_done itself stays set.
- If o_count > i_limit (limit lowered at runtime): next step up yields 0 (WRAP, with o_wrap) or i_limit (SAT/ONESHOT, with o_tc). Next step down decrements normally.
- i_limit = 0: every up or down step is at terminal. WRAP pulses o_wrap on each tick with o_count = 0; the first tick into 0 pulses o_tc.
- i_dir may change any cycle; the new direction applies to the next step.
- Reset mid-operation: async clear of all state; the first step after release requires a full prescale period.
- Arithmetic is modulo 2**WIDTH internally but never observable, due to the limit checks.

Decomposition:
- Package counter_pkg:
  - mode enum: MODE_WRAP = 2'd0, MODE_SAT = 2'd1, MODE_ONESHOT = 2'd2
  - direction constants: DIR_UP = 1'b1, DIR_DOWN = 1'b0
- Sub-module counter_prescaler (params PRESCALE_W):
  - inputs: clk, resetn, i_enable, i_sync_clr, i_div
  - output: o_tick
- Top holds the count/mode logic.

Test Plan:
1. Reset, WIDTH=8, i_limit=5, WRAP, up, i_prescale=0, enable for 8 cycles -> count 1,2,3,4,5,0,1,2; o_tc with count 5; o_wrap with count 0.
2. SAT, down, load 3, enable 6 cycles -> count 2,1,0,0,0,0; o_tc once (with 0); o_wrap never.
3. ONESHOT, up, i_limit=3, enable held -> count 1,2,3 then holds; o_done=1 from count 3 on; i_load=1 with i_load_val=9 -> count 3 (clamped), o_done=0.
4. i_prescale=2, WRAP up, enable held 9 cycles -> count steps every 3rd cycle to 1,2,3; deassert enable for 2 cycles mid-period -> no step, phase preserved.
5. Count=7, i_limit lowered to 4: step up in SAT -> 4 with o_tc; in WRAP -> 0 with o_wrap. Same-cycle i_clear and i_load -> count = RESET_VAL.
6. Async resetn pulse mid-count at 5 with pre_cnt=1 -> o_count=0 and all flags 0 immediately; after release, the first step occurs i_prescale+1 enabled cycles later.
